// File: rtl/full_adder_8_bit_data_flow.sv
// 8-bit ripple-carry adder/subtractor built from data-flow full-adder cells.
// One cycle of latency: inputs sampled at a rising edge drive the output registers.
module full_adder_8_bit_data_flow (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  input  logic       sel,
  output logic [7:0] sum,
  output logic       c_out,
  output logic       over_flow
);

  logic [7:0] bx;
  logic [8:0] c;
  logic [7:0] s;

  logic [7:0] sum_q,  sum_d;
  logic       c_out_q, c_out_d;
  logic       ovf_q,  ovf_d;

  // Subtraction is a + ~b + ~c_in, so c_in acts as borrow-in when sel=1.
  assign bx   = b ^ {8{sel}};
  assign c[0] = c_in ^ sel;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign sum_d   = s;
  assign c_out_d = c[8];
  assign ovf_d   = c[7] ^ c[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 8'h00;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign over_flow = ovf_q;

endmodule

// File: tb/tb_full_adder_8_bit_data_flow.sv
// Self-checking bench for full_adder_8_bit_data_flow: directed, boundary,
// reset and randomized back-to-back operations against an arithmetic model.
module tb_full_adder_8_bit_data_flow;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0, sel = 1'b0;
  logic [7:0] sum;
  logic       c_out, over_flow;

  int n_cmp = 0;
  int n_bad = 0;

  full_adder_8_bit_data_flow dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .sel(sel),
    .sum(sum), .c_out(c_out), .over_flow(over_flow)
  );

  always #5 clk = ~clk;

  // Returns {over_flow, c_out, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] ai, input logic [7:0] bi,
                                       input logic ci, input logic op);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = ai; ub = bi;
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    if (!op) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      co = (ur > 255);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ur >= 0);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, co, 8'(ur & 255)};
  endfunction

  task automatic drive(input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci, input logic op);
    a = ai; b = bi; c_in = ci; sel = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h exp=%h", {over_flow, c_out, sum}, 10'h000);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== {1'b0, 1'b1, 8'hFF}) begin
      n_bad++;
      $display("FAIL reset_release got=%h exp=%h", {over_flow, c_out, sum}, {1'b0, 1'b1, 8'hFF});
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta[9] = '{8'h55, 8'hBB, 8'h11, 8'hFF, 8'h55, 8'h80, 8'hFF, 8'h7F, 8'h00};
    logic [7:0] tb[9] = '{8'h44, 8'h44, 8'h55, 8'h55, 8'h44, 8'h01, 8'h01, 8'h01, 8'h01};
    logic       ts[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0] te[9] = '{{1'b1, 1'b0, 8'h99}, {1'b0, 1'b0, 8'hFF}, {1'b0, 1'b0, 8'h66},
                          {1'b0, 1'b1, 8'h54}, {1'b0, 1'b1, 8'h11}, {1'b1, 1'b1, 8'h7F},
                          {1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}, {1'b0, 1'b0, 8'hFF}};
    for (int i = 0; i < 9; i++) begin
      drive(ta[i], tb[i], 1'b0, ts[i]);
      @(posedge clk); #1;
      n_cmp++;
      if ({over_flow, c_out, sum} !== te[i]) begin
        n_bad++;
        $display("FAIL directed_%0d got=%h exp=%h", i, {over_flow, c_out, sum}, te[i]);
      end
    end
  endtask

  task automatic test_borrow_in();
    // 0x10 - 0x05 - 1 = 0x0A, no borrow; 0x00 - 0x00 - 1 = 0xFF, borrow
    drive(8'h10, 8'h05, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== {1'b0, 1'b1, 8'h0A}) begin
      n_bad++;
      $display("FAIL borrow_in_a got=%h exp=%h", {over_flow, c_out, sum}, {1'b0, 1'b1, 8'h0A});
    end
    drive(8'h00, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== {1'b0, 1'b0, 8'hFF}) begin
      n_bad++;
      $display("FAIL borrow_in_b got=%h exp=%h", {over_flow, c_out, sum}, {1'b0, 1'b0, 8'hFF});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp, prev;
    logic [7:0] ra, rb;
    logic rc, rs;
    prev = {over_flow, c_out, sum};
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      drive(ra, rb, rc, rs);
      exp = model(ra, rb, rc, rs);
      #2;
      n_cmp++;
      if ({over_flow, c_out, sum} !== prev) begin
        n_bad++;
        $display("FAIL hold_%0d got=%h exp=%h", i, {over_flow, c_out, sum}, prev);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({over_flow, c_out, sum} !== exp) begin
        n_bad++;
        $display("FAIL random_%0d a=%h b=%h ci=%b sel=%b got=%h exp=%h",
                 i, ra, rb, rc, rs, {over_flow, c_out, sum}, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_reset_midstream();
    logic [9:0] exp;
    drive(8'h7F, 8'h7F, 1'b1, 1'b0);
    exp = model(8'h7F, 8'h7F, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== exp) begin
      n_bad++;
      $display("FAIL pre_reset got=%h exp=%h", {over_flow, c_out, sum}, exp);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== exp) begin
      n_bad++;
      $display("FAIL reset_not_async got=%h exp=%h", {over_flow, c_out, sum}, exp);
    end
    drive(8'hC3, 8'h5A, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_mid got=%h exp=%h", {over_flow, c_out, sum}, 10'h000);
    end
    rst = 1'b0;
    exp = model(8'hC3, 8'h5A, 1'b1, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if ({over_flow, c_out, sum} !== exp) begin
      n_bad++;
      $display("FAIL post_reset got=%h exp=%h", {over_flow, c_out, sum}, exp);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_borrow_in();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
